// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, FSM state encoding, NOP word.
package if_stage_pkg;

  localparam int ARQUITECTURE_BITS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } if_state_e;

  localparam logic [ARQUITECTURE_BITS-1:0] NOP = '0;

endpackage

// File: rtl/if_instruction_memory.sv
// Sequentially loaded instruction memory with rising-edge write detect and combinational read at PC.
// Build option: IF_PC_WRAP_EN makes the read index wrap modulo the memory depth instead of returning NOP.
module if_instruction_memory
  import if_stage_pkg::*;
#(
  parameter int PC_SIZE            = ARQUITECTURE_BITS,
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_write_mem,
  input  logic               i_block_write,
  input  logic [PC_SIZE-1:0] i_instruction,
  input  logic [PC_SIZE-1:0] i_pc,
  output logic               o_full_mem,
  output logic               o_empty_mem,
  output logic [PC_SIZE-1:0] o_instruction
);

  localparam int ADDR_LSB = $clog2(WORD_SIZE_IN_BYTES);
  localparam int IDX_W    = (MEM_SIZE_IN_WORDS > 1) ? $clog2(MEM_SIZE_IN_WORDS) : 1;
  localparam int WP_W     = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic [PC_SIZE-1:0] r_mem [MEM_SIZE_IN_WORDS];
  logic [WP_W-1:0]    r_wptr;
  logic               r_write_prev;

  logic               w_write;
  logic [PC_SIZE-1:0] w_index;

  assign o_full_mem  = (r_wptr == WP_W'(MEM_SIZE_IN_WORDS));
  assign o_empty_mem = (r_wptr == '0);

  // One word per 0->1 transition of the load request, never while running or once full.
  assign w_write = i_write_mem && !r_write_prev && !o_full_mem && !i_block_write;
  assign w_index = i_pc >> ADDR_LSB;

  // NOTE: the memory array is reset explicitly because an empty memory must read back as NOPs;
  // this forces a flop-based array rather than an inferred RAM macro.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) r_mem[i] <= '0;
      r_wptr       <= '0;
      r_write_prev <= 1'b0;
    end else begin
      r_write_prev <= i_write_mem;
      if (w_write) begin
        r_mem[IDX_W'(r_wptr)] <= i_instruction;
        r_wptr                <= r_wptr + WP_W'(1);
      end
    end
  end

  // NOTE: o_instruction gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    o_instruction = PC_SIZE'(NOP);
`ifdef IF_PC_WRAP_EN
    o_instruction = r_mem[IDX_W'(w_index % PC_SIZE'(MEM_SIZE_IN_WORDS))];
`else
    if (w_index < PC_SIZE'(MEM_SIZE_IN_WORDS)) o_instruction = r_mem[IDX_W'(w_index)];
`endif
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register and IDLE/RUN/HALTED control around the instruction memory.
// Build option: IF_PC_WRAP_EN (see if_instruction_memory) wraps fetch past the last loaded word.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_SIZE            = ARQUITECTURE_BITS,
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halt,
  input  logic               i_not_load,
  input  logic               i_enable,
  input  logic               i_next_pc_src,
  input  logic               i_write_mem,
  input  logic [PC_SIZE-1:0] i_instruction,
  input  logic [PC_SIZE-1:0] i_next_not_seq_pc,
  output logic               o_full_mem,
  output logic               o_empty_mem,
  output logic [PC_SIZE-1:0] o_instruction,
  output logic [PC_SIZE-1:0] o_next_seq_pc
);

  if_state_e          r_state;
  logic [PC_SIZE-1:0] r_pc;
  logic [PC_SIZE-1:0] w_seq_pc;

  assign w_seq_pc      = r_pc + PC_SIZE'(WORD_SIZE_IN_BYTES);
  assign o_next_seq_pc = w_seq_pc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else if (i_enable) begin
      unique case (r_state)
        IDLE, HALTED: begin
          // Start outranks a simultaneous halt; the halt is seen again once running.
          if (i_start) begin
            r_state <= RUN;
            r_pc    <= '0;
          end
        end
        RUN: begin
          if (i_halt)             r_state <= HALTED;
          else if (!i_not_load)   r_pc    <= i_next_pc_src ? i_next_not_seq_pc : w_seq_pc;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_instruction_memory #(
    .PC_SIZE           (PC_SIZE),
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES),
    .MEM_SIZE_IN_WORDS (MEM_SIZE_IN_WORDS)
  ) u_imem (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_write_mem  (i_write_mem),
    .i_block_write(r_state == RUN),
    .i_instruction(i_instruction),
    .i_pc         (r_pc),
    .o_full_mem   (o_full_mem),
    .o_empty_mem  (o_empty_mem),
    .o_instruction(o_instruction)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 20-word memory: load, run, stall, halt, restart, redirect, reset.
module tb_if_stage;

  localparam int PCW = 32;
  localparam int MEM = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, halt, not_load, enable, pc_src, write_mem;
  logic [PCW-1:0] instr_in, target;
  logic           full_mem, empty_mem;
  logic [PCW-1:0] instr_out, next_seq_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_stage #(
    .PC_SIZE           (PCW),
    .WORD_SIZE_IN_BYTES(4),
    .MEM_SIZE_IN_WORDS (MEM)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_start          (start),
    .i_halt           (halt),
    .i_not_load       (not_load),
    .i_enable         (enable),
    .i_next_pc_src    (pc_src),
    .i_write_mem      (write_mem),
    .i_instruction    (instr_in),
    .i_next_not_seq_pc(target),
    .o_full_mem       (full_mem),
    .o_empty_mem      (empty_mem),
    .o_instruction    (instr_out),
    .o_next_seq_pc    (next_seq_pc)
  );

  function automatic logic [PCW-1:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  task automatic check(input string tag, input logic [PCW-1:0] obs, input logic [PCW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [PCW-1:0] exp_instr, input logic [PCW-1:0] exp_next);
    check({tag, "_instr"}, instr_out, exp_instr);
    check({tag, "_next"}, next_seq_pc, exp_next);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; not_load = 1'b0; enable = 1'b1;
    pc_src = 1'b0; write_mem = 1'b0; instr_in = '0; target = '0;
    #1;
    check("rst_empty", 32'(empty_mem), 32'd1);
    check("rst_full", 32'(full_mem), 32'd0);
    fetch("rst", 32'h0, 32'd4);
    step(); step();
    rst_n = 1'b1;
    step();

    // Load 20 words, each request held for three cycles.
    for (int i = 0; i < MEM; i++) begin
      instr_in  = word(i);
      write_mem = 1'b1;
      repeat (3) step();
      write_mem = 1'b0;
      if (i == 0) check("empty_after_first", 32'(empty_mem), 32'd0);
      if (i == MEM - 2) check("not_full_at_19", 32'(full_mem), 32'd0);
      step();
    end
    check("full_after_20", 32'(full_mem), 32'd1);

    // A 21st pulse must not overwrite anything.
    instr_in  = 32'hDEAD_BEEF;
    write_mem = 1'b1;
    repeat (2) step();
    write_mem = 1'b0;
    step();
    check("full_after_21", 32'(full_mem), 32'd1);
    fetch("idle_read", word(0), 32'd4);

    // Start and run sequentially.
    start = 1'b1; step(); start = 1'b0;
    fetch("start", word(0), 32'd4);
    for (int k = 1; k <= 5; k++) begin
      step();
      fetch($sformatf("seq%0d", k), word(k), 32'(4 * k + 4));
    end

    // Enable low freezes PC for five cycles.
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      fetch($sformatf("dis%0d", k), word(5), 32'd24);
    end
    enable = 1'b1;
    step();
    fetch("resume", word(6), 32'd28);

    // Halt freezes PC indefinitely.
    halt = 1'b1; step(); halt = 1'b0;
    fetch("halt", word(6), 32'd28);
    repeat (5) step();
    fetch("halted", word(6), 32'd28);

    // Start together with halt in HALTED: start wins, then run continues.
    start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
    fetch("restart", word(0), 32'd4);
    step();
    fetch("restart_seq", word(1), 32'd8);

    // Stall five cycles with a redirect present; the redirect is lost.
    not_load = 1'b1; pc_src = 1'b1; target = 32'd40;
    for (int k = 0; k < 5; k++) begin
      step();
      fetch($sformatf("stall%0d", k), word(1), 32'd8);
    end
    not_load = 1'b0; pc_src = 1'b0;
    step();
    fetch("unstall", word(2), 32'd12);

    // Run past the last loaded word: PC=80 reads NOP.
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k < 18) check($sformatf("run%0d_instr", k), instr_out, word(2 + k));
    end
    fetch("past_end", 32'h0, 32'd84);

    // One-cycle redirect to byte address 40 (word 10).
    target = 32'd40; pc_src = 1'b1; step(); pc_src = 1'b0;
    fetch("redirect", word(10), 32'd44);
    step();
    fetch("redirect_seq", word(11), 32'd48);

    // Start is ignored while running.
    start = 1'b1; step(); start = 1'b0;
    fetch("start_in_run", word(12), 32'd52);

    // Asynchronous reset mid-run clears PC, pointer and memory.
    #2 rst_n = 1'b0;
    #1;
    check("areset_empty", 32'(empty_mem), 32'd1);
    check("areset_full", 32'(full_mem), 32'd0);
    fetch("areset", 32'h0, 32'd4);
    step();
    rst_n = 1'b1;
    step();
    fetch("post_reset_idle", 32'h0, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS-style pipeline.
- Holds a small instruction memory that the debug/loader unit fills sequentially, plus the program counter (PC).
- Presents the instruction at PC and PC+4 to the IF/ID register.
- Controlled by start/halt/enable/stall signals from the debug unit and by branch/jump redirects from later stages.

Parameters:
- PC_SIZE, 32, width of PC, instructions and redirect address (ARQUITECTURE_BITS)
- WORD_SIZE_IN_BYTES, 4, bytes per instruction word; PC step
- MEM_SIZE_IN_WORDS, 10, instruction memory depth in words

Ports:
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous reset, active-low
- i_start  in  1  start program execution from address 0
- i_halt  in  1  stop fetching (program end or debug stop)
- i_not_load  in  1  stall: PC holds its value
- i_enable  in  1  global clock enable for PC/state update (debug step control)
- i_next_pc_src  in  1  1 = take i_next_not_seq_pc, 0 = PC+WORD_SIZE_IN_BYTES
- i_write_mem  in  1  load-request level; one word written per 0→1 transition
- i_instruction  in  PC_SIZE  word to load into memory
- i_next_not_seq_pc  in  PC_SIZE  branch/jump target (byte address)
- o_full_mem  out  1  write pointer == MEM_SIZE_IN_WORDS
- o_empty_mem  out  1  write pointer == 0
- o_instruction  out  PC_SIZE  memory word at PC (combinational)
- o_next_seq_pc  out  PC_SIZE  PC + WORD_SIZE_IN_BYTES (combinational)

Behaviour:
- Reset (i_reset low, async):
  - PC = 0, state = IDLE, write pointer = 0, all memory words = 0, edge-detect register = 0.
  - Outputs: o_empty_mem = 1, o_full_mem = 0, o_instruction = 0, o_next_seq_pc = 4.
- Loading:
  - A write occurs on a rising clock edge where i_write_mem = 1 and its registered previous value = 0 (one word per pulse, regardless of pulse length).
  - On a write: mem[wptr] <= i_instruction; wptr++.
  - Writes are ignored when full or while in RUN. No wrap-around.
  - o_full_mem and o_empty_mem are combinational from wptr.
- State machine (updates only when i_enable = 1, except reset):
  - IDLE: i_start → RUN with PC <= 0.
  - RUN: evaluated in priority order:
    - i_halt → HALTED, PC holds
    - else i_not_load → PC holds
    - else i_next_pc_src → PC <= i_next_not_seq_pc
    - else PC <= PC + WORD_SIZE_IN_BYTES
  - RUN: i_start is ignored.
  - HALTED: PC frozen; i_start → RUN with PC <= 0.
  - i_enable = 0: PC and state frozen in every state; memory loading is unaffected.
- Read:
  - o_instruction = mem[PC / WORD_SIZE_IN_BYTES], indexed with PC's low log2(WORD_SIZE_IN_BYTES) bits ignored.
  - Index ≥ MEM_SIZE_IN_WORDS → 0 (NOP).
  - The read is valid in every state, including IDLE and HALTED.
- Arithmetic: PC + WORD_SIZE_IN_BYTES is modulo 2^PC_SIZE. Redirect targets are not range-checked.
- Same-edge conflicts:
  - i_start + i_halt in IDLE/HALTED: start wins; the halt is evaluated from the next cycle.
  - A redirect while stalled is lost.

Optional Feature:
- IF_PC_WRAP_EN
  - Defined: the memory index is taken modulo MEM_SIZE_IN_WORDS, so sequential fetch wraps to word 0 and never returns the out-of-range 0.
  - Undefined: out-of-range index returns 0 as specified above.

Decomposition:
- Shared package holds:
  - ARQUITECTURE_BITS (32)
  - state encoding localparams IDLE/RUN/HALTED
  - NOP word constant (0)
- Natural sub-module: if_instruction_memory, containing the write pointer, write edge detect, full/empty flags and the read mux.
- PC register and state machine stay in if_stage.

Test Plan:
- Reset, then load 20 distinct words (MEM_SIZE_IN_WORDS = 20), each held high for several cycles → exactly 20 writes; o_empty_mem falls after the first write; o_full_mem = 1 after the 20th; a 21st pulse is ignored.
- i_enable = 1, pulse i_start → o_instruction sequences word0, word1, …; o_next_seq_pc = 4, 8, 12, … one step per cycle.
- Drop i_enable for 5 cycles mid-run → o_instruction and o_next_seq_pc constant; resuming continues from the same PC.
- Pulse i_halt → PC frozen indefinitely; then pulse i_start → fetch restarts at word0, o_next_seq_pc = 4.
- Hold i_not_load for 5 cycles → PC frozen. Release and run past word19 → o_instruction = 0 at PC = 80 (without IF_PC_WRAP_EN).
- i_next_not_seq_pc = 40, one-cycle i_next_pc_src → next o_instruction = word10, o_next_seq_pc = 44, then sequential from there.
